// File: rtl/bg_pkg.sv
// Shared VGA timing constants, background geometry and layout encoding for the
// background scan-out path.
package bg_pkg;

    // Horizontal timing in pixel ticks: active, front porch, sync, back porch
    localparam logic [9:0] H_ACTIVE     = 10'd640;
    localparam logic [9:0] H_FP         = 10'd16;
    localparam logic [9:0] H_SYNC       = 10'd96;
    localparam logic [9:0] H_BP         = 10'd48;
    localparam logic [9:0] H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] H_SYNC_START = H_ACTIVE + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;

    // Vertical timing in lines: active, front porch, sync, back porch
    localparam logic [9:0] V_ACTIVE     = 10'd480;
    localparam logic [9:0] V_FP         = 10'd10;
    localparam logic [9:0] V_SYNC       = 10'd2;
    localparam logic [9:0] V_BP         = 10'd33;
    localparam logic [9:0] V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] V_SYNC_START = V_ACTIVE + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    // Background framebuffer geometry
    localparam logic [9:0] BG_W   = 10'd640;
    localparam logic [9:0] BG_H   = 10'd480;
    localparam logic [9:0] HALF_W = 10'd320;
    localparam logic [9:0] HALF_H = 10'd240;

    typedef enum logic [1:0] {
        LAYOUT_HSCROLL = 2'd0,
        LAYOUT_VSCROLL = 2'd1,
        LAYOUT_BOTH    = 2'd2,
        LAYOUT_QUAD    = 2'd3
    } layout_t;

    // Codes 4..7 are unused and fall back to plain horizontal scrolling
    function automatic layout_t decode_layout(input logic [2:0] raw);
        return raw[2] ? LAYOUT_HSCROLL : layout_t'(raw[1:0]);
    endfunction

    // Add two in-range coordinates with one conditional subtract; both inputs
    // are below limit, so a single subtract always lands back in range.
    function automatic logic [9:0] wrap_add(input logic [9:0] a,
                                            input logic [9:0] b,
                                            input logic [9:0] limit);
        logic [10:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, limit}) begin
            sum = sum - {1'b0, limit};
        end
        return sum[9:0];
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 800x525 VGA raster counters with undelayed data-enable and sync decode.
module vga_timing_gen
    import bg_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_ce,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       de_raw,
    output logic       hsync_n_raw,
    output logic       vsync_n_raw,
    output logic       latch_point
);

    logic [9:0] h_count_reg;
    logic [9:0] v_count_reg;

    // Raster position: h wraps at the line end, v steps on each h wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            h_count_reg <= 10'd0;
            v_count_reg <= 10'd0;
        end else if (pix_ce) begin
            if (h_count_reg == H_TOTAL - 10'd1) begin
                h_count_reg <= 10'd0;
                if (v_count_reg == V_TOTAL - 10'd1) begin
                    v_count_reg <= 10'd0;
                end else begin
                    v_count_reg <= v_count_reg + 10'd1;
                end
            end else begin
                h_count_reg <= h_count_reg + 10'd1;
            end
        end
    end

    assign h_count     = h_count_reg;
    assign v_count     = v_count_reg;
    assign de_raw      = (h_count_reg < H_ACTIVE) && (v_count_reg < V_ACTIVE);
    assign hsync_n_raw = !((h_count_reg >= H_SYNC_START) && (h_count_reg < H_SYNC_END));
    assign vsync_n_raw = !((v_count_reg >= V_SYNC_START) && (v_count_reg < V_SYNC_END));
    // First blanked line, first pixel: the only point new scroll values are taken
    assign latch_point = (h_count_reg == 10'd0) && (v_count_reg == V_ACTIVE);

endmodule

// File: rtl/background_scanout.sv
// Scrolling / mirrored background scan-out: maps the raster position to a
// framebuffer address and returns the fetched pixel with aligned syncs.
module background_scanout
    import bg_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic [9:0]  x_position,
    input  logic [9:0]  y_position,
    input  logic [2:0]  layout,
    output logic [18:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  pixel_out,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic        vblank_start
);

    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        de_raw;
    logic        hsync_n_raw;
    logic        vsync_n_raw;
    logic        latch_point;

    logic [9:0]  x_off_reg;
    logic [9:0]  y_off_reg;
    layout_t     lay_reg;
    logic [9:0]  x_off_next;
    logic [9:0]  y_off_next;

    logic [9:0]  h_src;
    logic [9:0]  v_src;
    logic [9:0]  sx;
    logic [9:0]  sy;
    logic [18:0] addr_next;

    logic [18:0] mem_addr_reg;
    logic        de_d1_reg;
    logic        hsync_n_d1_reg;
    logic        vsync_n_d1_reg;
    logic [7:0]  pixel_out_reg;
    logic        de_reg;
    logic        hsync_n_reg;
    logic        vsync_n_reg;
    logic        vblank_start_reg;

    vga_timing_gen u_timing (
        .clk         (clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .h_count     (h_count),
        .v_count     (v_count),
        .de_raw      (de_raw),
        .hsync_n_raw (hsync_n_raw),
        .vsync_n_raw (vsync_n_raw),
        .latch_point (latch_point)
    );

    // Reduce requested scroll into the background size (x: one subtract, y: up to two)
    always_comb begin
        x_off_next = x_position;
        if (x_position >= BG_W) begin
            x_off_next = x_position - BG_W;
        end
        y_off_next = y_position;
        if (y_position >= (BG_H << 1)) begin
            y_off_next = y_position - (BG_H << 1);
        end else if (y_position >= BG_H) begin
            y_off_next = y_position - BG_H;
        end
    end

    // Scroll offsets and layout only change at the vblank latch point
    always_ff @(posedge clk) begin
        if (reset) begin
            x_off_reg        <= 10'd0;
            y_off_reg        <= 10'd0;
            lay_reg          <= LAYOUT_HSCROLL;
            vblank_start_reg <= 1'b0;
        end else begin
            vblank_start_reg <= 1'b0;
            if (pix_ce && latch_point) begin
                x_off_reg        <= x_off_next;
                y_off_reg        <= y_off_next;
                lay_reg          <= decode_layout(layout);
                vblank_start_reg <= 1'b1;
            end
        end
    end

    // Source coordinate: optional quad mirror, then per-axis wrapped scroll
    always_comb begin
        h_src = h_count;
        v_src = v_count;
        if (lay_reg == LAYOUT_QUAD) begin
            if (h_count >= HALF_W) begin
                h_src = BG_W - 10'd1 - h_count;
            end
            if (v_count >= HALF_H) begin
                v_src = BG_H - 10'd1 - v_count;
            end
        end
        sx = wrap_add(h_src, x_off_reg, BG_W);
        sy = wrap_add(v_src, y_off_reg, BG_H);
        if (lay_reg == LAYOUT_VSCROLL) begin
            sx = h_src;
        end
        if (lay_reg == LAYOUT_HSCROLL) begin
            sy = v_src;
        end
        // sy*640 as two shifts, so no multiplier is needed
        addr_next = ({9'd0, sy} << 9) + ({9'd0, sy} << 7) + {9'd0, sx};
    end

    // Stage 1: issue the fetch address (held in blanking) and delay raw timing
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_reg   <= 19'd0;
            de_d1_reg      <= 1'b0;
            hsync_n_d1_reg <= 1'b1;
            vsync_n_d1_reg <= 1'b1;
        end else if (pix_ce) begin
            if (de_raw) begin
                mem_addr_reg <= addr_next;
            end
            de_d1_reg      <= de_raw;
            hsync_n_d1_reg <= hsync_n_raw;
            vsync_n_d1_reg <= vsync_n_raw;
        end
    end

    // Stage 2: capture the fetched pixel alongside its timing, blank outside active
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_out_reg <= 8'd0;
            de_reg        <= 1'b0;
            hsync_n_reg   <= 1'b1;
            vsync_n_reg   <= 1'b1;
        end else if (pix_ce) begin
            pixel_out_reg <= de_d1_reg ? mem_rdata : 8'd0;
            de_reg        <= de_d1_reg;
            hsync_n_reg   <= hsync_n_d1_reg;
            vsync_n_reg   <= vsync_n_d1_reg;
        end
    end

    assign mem_addr     = mem_addr_reg;
    assign pixel_out    = pixel_out_reg;
    assign de           = de_reg;
    assign hsync_n      = hsync_n_reg;
    assign vsync_n      = vsync_n_reg;
    assign vblank_start = vblank_start_reg;

endmodule

// File: tb/tb_background_scanout.sv
// Bench for background_scanout: a tick-indexed raster model checked every
// clock, plus directed points with hand-computed addresses.
module tb_background_scanout;

    localparam int F      = 420000;   // ticks per frame (800*525)
    localparam int LATCH  = 480 * 800; // tick index of h=0, v=480 within a frame
    localparam int BUDGET = 2000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_ce;
    logic [9:0]  x_position;
    logic [9:0]  y_position;
    logic [2:0]  layout;
    logic [18:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic [7:0]  pixel_out;
    logic        hsync_n;
    logic        vsync_n;
    logic        de;
    logic        vblank_start;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    background_scanout dut (
        .clk          (clk),
        .reset        (reset),
        .pix_ce       (pix_ce),
        .x_position   (x_position),
        .y_position   (y_position),
        .layout       (layout),
        .mem_addr     (mem_addr),
        .mem_rdata    (mem_rdata),
        .pixel_out    (pixel_out),
        .hsync_n      (hsync_n),
        .vsync_n      (vsync_n),
        .de           (de),
        .vblank_start (vblank_start)
    );

    // Framebuffer contents: a fixed scramble of the address
    function automatic logic [7:0] pix_of(input int a);
        return 8'((a * 37 + a / 256 + 11) % 256);
    endfunction

    assign mem_rdata = pix_of(int'(mem_addr));

    // Raster helpers on an absolute tick index
    function automatic bit act(input int n);
        return ((n % 800) < 640) && (((n / 800) % 525) < 480);
    endfunction

    function automatic bit hs_low(input int n);
        return ((n % 800) >= 656) && ((n % 800) < 752);
    endfunction

    function automatic bit vs_low(input int n);
        return (((n / 800) % 525) == 490) || (((n / 800) % 525) == 491);
    endfunction

    // Source address for a screen position under a given scroll/layout
    function automatic int addr_of(input int n, input int xo, input int yo, input int ly);
        int h, v, sx, sy;
        h = n % 800;
        v = (n / 800) % 525;
        if (ly == 3) begin
            if (h >= 320) h = 639 - h;
            if (v >= 240) v = 479 - v;
        end
        sx = (ly == 1) ? h : (h + xo) % 640;
        sy = (ly == 0) ? v : (v + yo) % 480;
        return sy * 640 + sx;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input int want, input bit loud);
        total++;
        if (got !== want) begin
            bad++;
            if (bad <= 25) $display("FAIL %s got=%0d want=%0d at t=%0t", name, got, want, $time);
        end else if (loud) begin
            $display("check %s got=%0d want=%0d ok", name, got, want);
        end
    endtask

    // Model state: m_n counts pix ticks since reset
    bit   m_valid = 1'b0;
    int   m_n, m_xo, m_yo, m_ly, e_addr;
    logic [7:0] e_pix;
    logic e_de, e_hs, e_vs, e_vb;

    // Model: after the tick that sees position n, mem_addr belongs to n and the
    // other outputs to n-1
    always @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b1;
            m_n     <= 0;
            m_xo    <= 0;
            m_yo    <= 0;
            m_ly    <= 0;
            e_addr  <= 0;
            e_pix   <= 8'd0;
            e_de    <= 1'b0;
            e_hs    <= 1'b1;
            e_vs    <= 1'b1;
            e_vb    <= 1'b0;
        end else begin
            e_vb <= 1'b0;
            if (pix_ce) begin
                m_n <= m_n + 1;
                if (act(m_n)) e_addr <= addr_of(m_n, m_xo, m_yo, m_ly);
                if (m_n == 0) begin
                    e_pix <= 8'd0;
                    e_de  <= 1'b0;
                    e_hs  <= 1'b1;
                    e_vs  <= 1'b1;
                end else begin
                    e_de  <= act(m_n - 1);
                    e_hs  <= !hs_low(m_n - 1);
                    e_vs  <= !vs_low(m_n - 1);
                    e_pix <= act(m_n - 1) ? pix_of(addr_of(m_n - 1, m_xo, m_yo, m_ly)) : 8'd0;
                end
                if ((m_n % F) == LATCH) begin
                    e_vb <= 1'b1;
                    m_xo <= int'(x_position) % 640;
                    m_yo <= int'(y_position) % 480;
                    m_ly <= (layout > 3'd3) ? 0 : int'(layout);
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("mem_addr", 32'(mem_addr), e_addr, 1'b0);
            chk("pixel_out", 32'(pixel_out), int'(e_pix), 1'b0);
            chk("de", 32'(de), int'(e_de), 1'b0);
            chk("hsync_n", 32'(hsync_n), int'(e_hs), 1'b0);
            chk("vsync_n", 32'(vsync_n), int'(e_vs), 1'b0);
            chk("vblank_start", 32'(vblank_start), int'(e_vb), 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        int k;
        k = 0;
        while (m_n != target && k < BUDGET) begin
            tick();
            k++;
        end
        if (m_n != target) chk("run_to_budget", 32'(m_n), target, 1'b1);
    endtask

    task automatic reset_state_checks(input string tag);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0, 1'b1);
        chk({tag, "_pixel_out"}, 32'(pixel_out), 0, 1'b1);
        chk({tag, "_de"}, 32'(de), 0, 1'b1);
        chk({tag, "_hsync_n"}, 32'(hsync_n), 1, 1'b1);
        chk({tag, "_vsync_n"}, 32'(vsync_n), 1, 1'b1);
        chk({tag, "_vblank_start"}, 32'(vblank_start), 0, 1'b1);
    endtask

    initial begin
        #40000000;
        $display("FAIL watchdog expired m_n=%0d", m_n);
        $fatal(1, "watchdog");
    end

    initial begin
        int de_cnt, hs_cnt, de_first, hs_first, c;
        de_cnt = 0; hs_cnt = 0; de_first = -1; hs_first = -1;
        reset = 1'b1; pix_ce = 1'b0;
        x_position = 10'd0; y_position = 10'd0; layout = 3'd0;
        repeat (3) tick();
        reset_state_checks("reset");

        // First line after reset: de span and hsync position/width
        reset = 1'b0; pix_ce = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            tick();
            if (de === 1'b1) begin
                de_cnt++;
                if (de_first < 0) de_first = k;
            end
            if (hsync_n === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = k;
            end
        end
        chk("de_ticks_per_line", 32'(de_cnt), 640, 1'b1);
        chk("de_first_tick", 32'(de_first), 2, 1'b1);
        chk("hsync_low_ticks", 32'(hs_cnt), 96, 1'b1);
        chk("hsync_start_tick", 32'(hs_first), 658, 1'b1);

        // Sparse pix_ce around v=200, then reset coinciding with a tick
        run_to(199 * 800 + 700);
        c = 0;
        while (m_n != 200 * 800 + 5 && c < 3000) begin
            pix_ce = (c % 3 == 0);
            tick();
            c++;
        end
        pix_ce = 1'b0;
        tick();
        pix_ce = 1'b1; reset = 1'b1;
        tick();
        pix_ce = 1'b0; reset = 1'b0;
        reset_state_checks("midframe_reset");
        c = 0;
        while (m_n != 5 && c < 100) begin
            pix_ce = (c % 3 == 0);
            tick();
            c++;
        end
        chk("restart_addr_h4", 32'(mem_addr), 4, 1'b1);

        // Frame 0 latches layout 0, x=700 (x_off=60)
        pix_ce = 1'b1; layout = 3'd0; x_position = 10'd700; y_position = 10'd0;
        run_to(F + 5 * 800 + 1);
        chk("hscroll_v5_h0", 32'(mem_addr), 3260, 1'b1);
        tick();
        chk("hscroll_pixel_v5_h0", 32'(pixel_out), int'(pix_of(3260)), 1'b1);
        run_to(F + 5 * 800 + 601);
        chk("hscroll_v5_h600", 32'(mem_addr), 3220, 1'b1);

        // Change inputs mid-frame; current frame keeps the old scroll
        run_to(F + 100 * 800);
        layout = 3'd1; x_position = 10'd100; y_position = 10'd1023;
        run_to(F + 100 * 800 + 11);
        chk("midframe_unchanged_v100_h10", 32'(mem_addr), 64070, 1'b1);
        run_to(F + LATCH + 1);
        chk("vblank_pulse", 32'(vblank_start), 1, 1'b1);
        tick();
        chk("vblank_pulse_end", 32'(vblank_start), 0, 1'b1);

        // Frame 2: layout 1, y_off=63
        run_to(2 * F + 1);
        chk("vscroll_v0_h0", 32'(mem_addr), 40320, 1'b1);
        run_to(2 * F + 450 * 800 + 11);
        chk("vscroll_v450_h10", 32'(mem_addr), 21130, 1'b1);
        run_to(2 * F + 460 * 800);
        layout = 3'd3; x_position = 10'd0; y_position = 10'd0;

        // Frame 3: quad mirror, zero offsets
        run_to(3 * F + 10 * 800 + 331);
        chk("quad_v10_h330", 32'(mem_addr), 6709, 1'b1);
        run_to(3 * F + 240 * 800 + 321);
        chk("quad_v240_h320", 32'(mem_addr), 153279, 1'b1);
        run_to(3 * F + 240 * 800 + 322);
        chk("quad_pixel_v240_h320", 32'(pixel_out), int'(pix_of(153279)), 1'b1);
        run_to(3 * F + 479 * 800 + 640);
        chk("quad_v479_h639", 32'(mem_addr), 0, 1'b1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
